// File: rtl/fifo_rr_input_if.sv
// Handshake/status bundle between an upstream source, the per-port FIFO and the arbiter.
// FIFO_ERR_FLAG_EN adds the sticky overflow/underflow error flags.
interface fifo_rr_input_if #(
    parameter int DATA_WIDTH = 10,
    parameter int ADDR_WIDTH = 3
);
    logic                  push;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  pop;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  valid_out;
    logic [ADDR_WIDTH:0]   count;
    logic                  empty;
    logic                  full;
    logic                  almost_full;
    logic                  almost_empty;
`ifdef FIFO_ERR_FLAG_EN
    logic                  overflow_err;
    logic                  underflow_err;
`endif

    modport master (
        output push,
        output data_in,
        output pop,
        input  data_out,
        input  valid_out,
        input  count,
        input  empty,
        input  full,
        input  almost_full,
`ifdef FIFO_ERR_FLAG_EN
        input  overflow_err,
        input  underflow_err,
`endif
        input  almost_empty
    );

    modport slave (
        input  push,
        input  data_in,
        input  pop,
        output data_out,
        output valid_out,
        output count,
        output empty,
        output full,
        output almost_full,
`ifdef FIFO_ERR_FLAG_EN
        output overflow_err,
        output underflow_err,
`endif
        output almost_empty
    );
endinterface

// File: rtl/fifo_rr_input.sv
// Per-port input FIFO feeding the round-robin arbiter; registered read data on pop.
// Optional sticky error flags enabled by defining FIFO_ERR_FLAG_EN.
module fifo_rr_input #(
    parameter int DATA_WIDTH = 10,
    parameter int ADDR_WIDTH = 3,
    parameter int AF_THRESH  = 6,
    parameter int AE_THRESH  = 2
) (
    input logic             i_clk,
    input logic             i_reset,
    fifo_rr_input_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   LP_DEPTH = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0]   LP_AF    = AF_THRESH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0]   LP_AE    = AE_THRESH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0]   LP_CNT1  = 1;
    localparam logic [ADDR_WIDTH-1:0] LP_PTR1  = 1;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_valid_out;

    logic w_empty;
    logic w_full;
    logic w_pop_acc;
    logic w_push_acc;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == LP_DEPTH);
    assign w_pop_acc  = bus.pop && !w_empty;
    // A pop in the same cycle frees a slot, so a full FIFO can still take a push.
    assign w_push_acc = bus.push && (!w_full || w_pop_acc);

    always_ff @(posedge i_clk) begin
        if (w_push_acc) begin
            r_mem[r_wr_ptr] <= bus.data_in;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_data_out  <= '0;
            r_valid_out <= 1'b0;
        end else begin
            r_valid_out <= w_pop_acc;
            if (w_push_acc) begin
                r_wr_ptr <= r_wr_ptr + LP_PTR1;
            end
            if (w_pop_acc) begin
                r_data_out <= r_mem[r_rd_ptr];
                r_rd_ptr   <= r_rd_ptr + LP_PTR1;
            end
            if (w_push_acc && !w_pop_acc) begin
                r_count <= r_count + LP_CNT1;
            end else if (w_pop_acc && !w_push_acc) begin
                r_count <= r_count - LP_CNT1;
            end
        end
    end

`ifdef FIFO_ERR_FLAG_EN
    logic r_overflow_err;
    logic r_underflow_err;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_overflow_err  <= 1'b0;
            r_underflow_err <= 1'b0;
        end else begin
            if (bus.push && !w_push_acc) begin
                r_overflow_err <= 1'b1;
            end
            if (bus.pop && w_empty) begin
                r_underflow_err <= 1'b1;
            end
        end
    end

    assign bus.overflow_err  = r_overflow_err;
    assign bus.underflow_err = r_underflow_err;
`endif

    assign bus.data_out     = r_data_out;
    assign bus.valid_out    = r_valid_out;
    assign bus.count        = r_count;
    assign bus.empty        = w_empty;
    assign bus.full         = w_full;
    assign bus.almost_full  = (r_count >= LP_AF);
    assign bus.almost_empty = (r_count <= LP_AE);
endmodule

// File: tb/tb_fifo_rr_input.sv
// Directed bench for fifo_rr_input: ordering, full/empty boundaries, wrap and async reset.
// Error-flag checks are included when FIFO_ERR_FLAG_EN is defined.
module tb_fifo_rr_input;
    logic clk;
    logic reset;
    int   n_tests;
    int   n_fail;

    fifo_rr_input_if #(.DATA_WIDTH(10), .ADDR_WIDTH(3)) bus ();

    fifo_rr_input #(
        .DATA_WIDTH(10),
        .ADDR_WIDTH(3),
        .AF_THRESH (6),
        .AE_THRESH (2)
    ) dut (
        .i_clk  (clk),
        .i_reset(reset),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic p, input logic [9:0] d, input logic q);
        bus.push    = p;
        bus.data_in = d;
        bus.pop     = q;
        @(posedge clk);
        #1;
        bus.push = 1'b0;
        bus.pop  = 1'b0;
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        bus.push    = 1'b0;
        bus.pop     = 1'b0;
        bus.data_in = '0;
        reset       = 1'b1;

        // 1: reset state
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_ae", 32'(bus.almost_empty), 32'd1);
        chk("rst_full", 32'(bus.full), 32'd0);
        chk("rst_af", 32'(bus.almost_full), 32'd0);
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_valid", 32'(bus.valid_out), 32'd0);
        chk("rst_dout", 32'(bus.data_out), 32'd0);
`ifdef FIFO_ERR_FLAG_EN
        chk("rst_ovf", 32'(bus.overflow_err), 32'd0);
        chk("rst_udf", 32'(bus.underflow_err), 32'd0);
`endif

        // 2: push six words then pop them in order
        for (int i = 1; i <= 6; i++) begin
            step(1'b1, 10'(i), 1'b0);
        end
        chk("p6_count", 32'(bus.count), 32'd6);
        chk("p6_af", 32'(bus.almost_full), 32'd1);
        chk("p6_ae", 32'(bus.almost_empty), 32'd0);
        chk("p6_empty", 32'(bus.empty), 32'd0);
        for (int i = 1; i <= 6; i++) begin
            step(1'b0, 10'h0, 1'b1);
            chk("pop_data", 32'(bus.data_out), 32'(i));
            chk("pop_valid", 32'(bus.valid_out), 32'd1);
            chk("pop_count", 32'(bus.count), 32'(6 - i));
        end
        chk("drain_empty", 32'(bus.empty), 32'd1);
        step(1'b0, 10'h0, 1'b0);
        chk("idle_valid", 32'(bus.valid_out), 32'd0);
        chk("idle_hold", 32'(bus.data_out), 32'h006);

        // 3: fill to full, ninth push dropped
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 10'h3FF, 1'b0);
            chk("fill_full", 32'(bus.full), (i == 8) ? 32'd1 : 32'd0);
        end
        chk("fill_count", 32'(bus.count), 32'd8);
        step(1'b1, 10'h3FF, 1'b0);
        chk("drop_count", 32'(bus.count), 32'd8);
        chk("drop_full", 32'(bus.full), 32'd1);
        chk("drop_valid", 32'(bus.valid_out), 32'd0);
`ifdef FIFO_ERR_FLAG_EN
        chk("ovf_set", 32'(bus.overflow_err), 32'd1);
        chk("udf_clear", 32'(bus.underflow_err), 32'd0);
`endif

        // 4: push and pop together while full
        step(1'b1, 10'h155, 1'b1);
        chk("fpp_count", 32'(bus.count), 32'd8);
        chk("fpp_data", 32'(bus.data_out), 32'h3FF);
        chk("fpp_valid", 32'(bus.valid_out), 32'd1);
        for (int i = 1; i <= 7; i++) begin
            step(1'b0, 10'h0, 1'b1);
            chk("fdrain_data", 32'(bus.data_out), 32'h3FF);
        end
        step(1'b0, 10'h0, 1'b1);
        chk("f155_data", 32'(bus.data_out), 32'h155);
        chk("f155_count", 32'(bus.count), 32'd0);

        // 5: pop while empty, with a simultaneous push
        step(1'b1, 10'h2AA, 1'b1);
        chk("ep_valid", 32'(bus.valid_out), 32'd0);
        chk("ep_count", 32'(bus.count), 32'd1);
        chk("ep_hold", 32'(bus.data_out), 32'h155);
        step(1'b0, 10'h0, 1'b1);
        chk("ep_data", 32'(bus.data_out), 32'h2AA);
        chk("ep_valid2", 32'(bus.valid_out), 32'd1);
        chk("ep_count2", 32'(bus.count), 32'd0);
`ifdef FIFO_ERR_FLAG_EN
        chk("udf_set", 32'(bus.underflow_err), 32'd1);
`endif

        // 6: 16 push/pop pairs across pointer wrap, then mid-stream reset
        step(1'b1, 10'h100, 1'b0);
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 10'(32'h101 + i), 1'b1);
            chk("wrap_data", 32'(bus.data_out), 32'h100 + 32'(i));
            chk("wrap_count", 32'(bus.count), 32'd1);
        end
        step(1'b1, 10'h1F0, 1'b0);
        chk("pre_rst_count", 32'(bus.count), 32'd2);
        bus.pop = 1'b1;
        @(posedge clk);
        #1;
        chk("pre_rst_valid", 32'(bus.valid_out), 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_count", 32'(bus.count), 32'd0);
        chk("mid_rst_empty", 32'(bus.empty), 32'd1);
        chk("mid_rst_valid", 32'(bus.valid_out), 32'd0);
        chk("mid_rst_dout", 32'(bus.data_out), 32'd0);
`ifdef FIFO_ERR_FLAG_EN
        chk("mid_rst_ovf", 32'(bus.overflow_err), 32'd0);
        chk("mid_rst_udf", 32'(bus.underflow_err), 32'd0);
`endif
        bus.pop = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        step(1'b0, 10'h0, 1'b1);
        chk("post_rst_valid", 32'(bus.valid_out), 32'd0);
        chk("post_rst_count", 32'(bus.count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
